// File: rtl/param_updown_counter_pkg.sv
// rtl/param_updown_counter_pkg.sv - shared direction and mode constants for the up/down counter
package counter_defs;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;
endpackage

// File: rtl/param_updown_counter_next_logic.sv
// rtl/param_updown_counter_next_logic.sv - next-count and wrap-event decode for the up/down counter
module counter_next_logic
    import counter_defs::*;
#(
    parameter int              WIDTH    = 6,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_event
);
    localparam logic [WIDTH-1:0] MAX  = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Priority is clear > load > enable > hold; a limit hit flags an event in both modes.
    always_comb begin
        next_count = count;
        wrap_event = 1'b0;
        if (clear) begin
            next_count = ZERO;
        end else if (load) begin
            next_count = (load_val > MAX) ? MAX : load_val;
        end else if (enable) begin
            if (up_down == DIR_UP) begin
                if (count == MAX) begin
                    wrap_event = 1'b1;
                    next_count = (SATURATE == MODE_SAT) ? MAX : ZERO;
                end else begin
                    next_count = count + ONE;
                end
            end else begin
                if (count == ZERO) begin
                    wrap_event = 1'b1;
                    next_count = (SATURATE == MODE_SAT) ? ZERO : MAX;
                end else begin
                    next_count = count - ONE;
                end
            end
        end
    end
endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - modulo-N up/down counter with load, clear, compare match and wrap flags
module param_updown_counter
    import counter_defs::*;
#(
    parameter int              WIDTH    = 6,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             match,
    output logic             wrap_pulse,
    output logic             overflow
);
    localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] next_count;
    logic             wrap_event;

    counter_next_logic #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .enable     (enable),
        .up_down    (up_down),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .next_count (next_count),
        .wrap_event (wrap_event)
    );

    // match compares the value being registered so it lines up with count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            match      <= 1'b0;
            wrap_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            count      <= next_count;
            match      <= (next_count == cmp_val);
            wrap_pulse <= wrap_event;
            if (clear) begin
                overflow <= 1'b0;
            end else if (wrap_event) begin
                overflow <= 1'b1;
            end
        end
    end

    assign terminal = enable & (((up_down == DIR_UP) & (count == MAX)) |
                                ((up_down == DIR_DOWN) & (count == '0)));
endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - scoreboard bench for wrap, saturate and full-width counter builds
module tb_param_updown_counter;
    typedef struct {
        logic [5:0] count;
        logic       match;
        logic       wrap_pulse;
        logic       overflow;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_val = 6'd0;
    logic [5:0] cmp_val = 6'd0;

    logic [5:0] w_count, s_count, f_count;
    logic       w_terminal, w_match, w_wrap, w_overflow;
    logic       s_terminal, s_match, s_wrap, s_overflow;
    logic       f_terminal, f_match, f_wrap, f_overflow;

    param_updown_counter #(.WIDTH(6), .MAX_VAL(9), .SATURATE(0)) dut_w (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_val(load_val), .cmp_val(cmp_val), .count(w_count),
        .terminal(w_terminal), .match(w_match), .wrap_pulse(w_wrap), .overflow(w_overflow));

    param_updown_counter #(.WIDTH(6), .MAX_VAL(9), .SATURATE(1)) dut_s (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_val(load_val), .cmp_val(cmp_val), .count(s_count),
        .terminal(s_terminal), .match(s_match), .wrap_pulse(s_wrap), .overflow(s_overflow));

    param_updown_counter #(.WIDTH(6)) dut_f (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_val(load_val), .cmp_val(cmp_val), .count(f_count),
        .terminal(f_terminal), .match(f_match), .wrap_pulse(f_wrap), .overflow(f_overflow));

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (w_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", w_count); end
        checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", w_overflow); end
        checks++; if (w_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", w_wrap); end
        checks++; if (w_match !== 1'b0) begin errors++; $display("FAIL reset_match_forced: got %b expected 0", w_match); end
        @(negedge clock);
        reset = 1'b1;
        cmp_val = 6'd40;
        load_val = 6'd63; load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        tick();
        enable = 1'b0; load_val = 6'd17; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (f_count !== 6'd17) begin errors++; $display("FAIL pre_reset_count: got %0d expected 17", f_count); end
        checks++; if (f_overflow !== 1'b1) begin errors++; $display("FAIL pre_reset_overflow: got %b expected 1", f_overflow); end
        #2 reset = 1'b0;
        #1;
        checks++; if (f_count !== 6'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", f_count); end
        checks++; if (f_overflow !== 1'b0) begin errors++; $display("FAIL async_reset_overflow: got %b expected 0", f_overflow); end
        checks++; if (f_wrap !== 1'b0) begin errors++; $display("FAIL async_reset_wrap: got %b expected 0", f_wrap); end
        cmp_val = 6'd0;
        reset = 1'b1;
        tick();
        checks++; if (f_match !== 1'b1) begin errors++; $display("FAIL first_edge_match: got %b expected 1", f_match); end
        cmp_val = 6'd40;
    endtask

    task automatic test_up_wrap();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL wrap_clear_overflow: got %b expected 0", w_overflow); end
        enable = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sb.push_back('{count: 6'(i % 10), match: 1'b0, wrap_pulse: (i == 10), overflow: (i == 10)});
            tick();
            e = sb.pop_front();
            checks++; if (w_count !== e.count) begin errors++; $display("FAIL up_wrap_count[%0d]: got %0d expected %0d", i, w_count, e.count); end
            checks++; if (w_wrap !== e.wrap_pulse) begin errors++; $display("FAIL up_wrap_pulse[%0d]: got %b expected %b", i, w_wrap, e.wrap_pulse); end
            checks++; if (w_overflow !== e.overflow) begin errors++; $display("FAIL up_wrap_overflow[%0d]: got %b expected %b", i, w_overflow, e.overflow); end
        end
        enable = 1'b0;
        sb.push_back('{count: 6'd0, match: 1'b0, wrap_pulse: 1'b0, overflow: 1'b1});
        tick();
        e = sb.pop_front();
        checks++; if (w_wrap !== e.wrap_pulse) begin errors++; $display("FAIL up_wrap_hold_pulse: got %b expected %b", w_wrap, e.wrap_pulse); end
        checks++; if (w_overflow !== e.overflow) begin errors++; $display("FAIL up_wrap_sticky: got %b expected %b", w_overflow, e.overflow); end
    endtask

    task automatic test_down_saturate();
        logic [5:0] exp_c [4] = '{6'd1, 6'd0, 6'd0, 6'd0};
        logic       exp_p [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        clear = 1'b1;
        tick();
        clear = 1'b0; load_val = 6'd2; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (s_count !== 6'd2) begin errors++; $display("FAIL sat_load: got %0d expected 2", s_count); end
        enable = 1'b1; up_down = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{count: exp_c[i], match: 1'b0, wrap_pulse: exp_p[i], overflow: exp_p[i]});
            tick();
            e = sb.pop_front();
            checks++; if (s_count !== e.count) begin errors++; $display("FAIL sat_down_count[%0d]: got %0d expected %0d", i, s_count, e.count); end
            checks++; if (s_wrap !== e.wrap_pulse) begin errors++; $display("FAIL sat_down_pulse[%0d]: got %b expected %b", i, s_wrap, e.wrap_pulse); end
            checks++; if (s_overflow !== e.overflow) begin errors++; $display("FAIL sat_down_overflow[%0d]: got %b expected %b", i, s_overflow, e.overflow); end
        end
        enable = 1'b0; load_val = 6'd9; load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{count: 6'd9, match: 1'b0, wrap_pulse: 1'b1, overflow: 1'b1});
            tick();
            e = sb.pop_front();
            checks++; if (s_count !== e.count) begin errors++; $display("FAIL sat_up_hold[%0d]: got %0d expected %0d", i, s_count, e.count); end
            checks++; if (s_wrap !== e.wrap_pulse) begin errors++; $display("FAIL sat_up_pulse[%0d]: got %b expected %b", i, s_wrap, e.wrap_pulse); end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_clamp();
        load_val = 6'd50; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (w_count !== 6'd9) begin errors++; $display("FAIL clamp_wrap_dut: got %0d expected 9", w_count); end
        checks++; if (s_count !== 6'd9) begin errors++; $display("FAIL clamp_sat_dut: got %0d expected 9", s_count); end
        checks++; if (f_count !== 6'd50) begin errors++; $display("FAIL load_full_width: got %0d expected 50", f_count); end
        enable = 1'b1; up_down = 1'b1;
        tick();
        checks++; if (w_overflow !== 1'b1) begin errors++; $display("FAIL clamp_then_wrap_overflow: got %b expected 1", w_overflow); end
        clear = 1'b1; load = 1'b1; load_val = 6'd5;
        tick();
        clear = 1'b0; load = 1'b0; enable = 1'b0;
        checks++; if (w_count !== 6'd0) begin errors++; $display("FAIL clear_beats_load_count: got %0d expected 0", w_count); end
        checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL clear_beats_load_overflow: got %b expected 0", w_overflow); end
        checks++; if (w_wrap !== 1'b0) begin errors++; $display("FAIL clear_beats_load_pulse: got %b expected 0", w_wrap); end
    endtask

    task automatic test_match();
        logic       dir   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0] exp_c [4] = '{6'd6, 6'd7, 6'd6, 6'd5};
        logic       exp_m [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        cmp_val = 6'd7; load_val = 6'd5; load = 1'b1;
        sb.push_back('{count: 6'd5, match: 1'b0, wrap_pulse: 1'b0, overflow: 1'b0});
        tick();
        load = 1'b0;
        e = sb.pop_front();
        checks++; if (w_match !== e.match) begin errors++; $display("FAIL match_at_load5: got %b expected %b", w_match, e.match); end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_down = dir[i];
            sb.push_back('{count: exp_c[i], match: exp_m[i], wrap_pulse: 1'b0, overflow: 1'b0});
            tick();
            e = sb.pop_front();
            checks++; if (w_count !== e.count) begin errors++; $display("FAIL match_count[%0d]: got %0d expected %0d", i, w_count, e.count); end
            checks++; if (w_match !== e.match) begin errors++; $display("FAIL match_flag[%0d]: got %b expected %b", i, w_match, e.match); end
        end
        enable = 1'b0; load_val = 6'd7; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (w_match !== 1'b1) begin errors++; $display("FAIL match_on_load7: got %b expected 1", w_match); end
        cmp_val = 6'd40;
    endtask

    task automatic test_full_width();
        up_down = 1'b1; load_val = 6'd62; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (f_count !== 6'd62) begin errors++; $display("FAIL fw_load62: got %0d expected 62", f_count); end
        enable = 1'b1;
        #1;
        checks++; if (f_terminal !== 1'b0) begin errors++; $display("FAIL fw_term_at62: got %b expected 0", f_terminal); end
        tick();
        checks++; if (f_count !== 6'd63) begin errors++; $display("FAIL fw_count63: got %0d expected 63", f_count); end
        checks++; if (f_terminal !== 1'b1) begin errors++; $display("FAIL fw_term_at63_up: got %b expected 1", f_terminal); end
        up_down = 1'b0;
        #1;
        checks++; if (f_terminal !== 1'b0) begin errors++; $display("FAIL fw_term_at63_down: got %b expected 0", f_terminal); end
        up_down = 1'b1;
        #1;
        tick();
        checks++; if (f_count !== 6'd0) begin errors++; $display("FAIL fw_wrap_to0: got %0d expected 0", f_count); end
        checks++; if (f_wrap !== 1'b1) begin errors++; $display("FAIL fw_wrap_pulse: got %b expected 1", f_wrap); end
        checks++; if (f_terminal !== 1'b0) begin errors++; $display("FAIL fw_term_at0_up: got %b expected 0", f_terminal); end
        up_down = 1'b0;
        #1;
        checks++; if (f_terminal !== 1'b1) begin errors++; $display("FAIL fw_term_at0_down: got %b expected 1", f_terminal); end
        enable = 1'b0;
        #1;
        checks++; if (f_terminal !== 1'b0) begin errors++; $display("FAIL fw_term_disabled: got %b expected 0", f_terminal); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_load_clamp();
        test_match();
        test_full_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
